// File: rtl/avl_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : avl_arbiter
//  Purpose  : Two-master Avalon-MM arbiter (m0 = instruction fetch, m1 = data)
//             sharing a single slave; round-robin or fixed-priority to m1.
//  Revision : 1.0  initial release
// ============================================================================
module avl_arbiter #(
    parameter int PRIORITY_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_address,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    input  logic        m0_read,
    input  logic        m0_write,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,

    input  logic [31:0] m1_address,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    input  logic        m1_read,
    input  logic        m1_write,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,

    output logic [31:0] s_address,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    output logic        s_read,
    output logic        s_write,
    input  logic [31:0] s_readdata,
    input  logic        s_waitrequest,

    output logic [1:0]  grant,
    output logic        proto_err,
    output logic [15:0] m0_count,
    output logic [15:0] m1_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    localparam logic [15:0] c_CNT_ONE = 16'd1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant;
    logic        r_last;          // 1 = m1 owned the slave last
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;
    logic        r_perr;

    logic        w_req0;
    logic        w_req1;
    logic        w_ill0;
    logic        w_ill1;
    logic        w_done0;
    logic        w_done1;

    // A legal request is exactly one of read/write; both at once is a protocol error
    assign w_req0 = m0_read ^ m0_write;
    assign w_req1 = m1_read ^ m1_write;
    assign w_ill0 = m0_read & m0_write;
    assign w_ill1 = m1_read & m1_write;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and completion detection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_done0     = 1'b0;
        w_done1     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 && w_req1) begin
                    if (PRIORITY_MODE != 0) begin
                        w_state_nxt = ST_GNT1;
                    end else begin
                        w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
                    end
                end else if (w_req0) begin
                    w_state_nxt = ST_GNT0;
                end else if (w_req1) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!w_req0) begin
                    w_state_nxt = ST_IDLE;
                end else if (!s_waitrequest) begin
                    w_state_nxt = ST_IDLE;
                    w_done0     = 1'b1;
                end
            end
            ST_GNT1: begin
                if (!w_req1) begin
                    w_state_nxt = ST_IDLE;
                end else if (!s_waitrequest) begin
                    w_state_nxt = ST_IDLE;
                    w_done1     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant, ownership history, counters and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant <= 2'b00;
            r_last  <= 1'b1;
            r_cnt0  <= 16'h0000;
            r_cnt1  <= 16'h0000;
            r_perr  <= 1'b0;
        end else begin
            r_grant <= {w_state_nxt == ST_GNT1, w_state_nxt == ST_GNT0};
            if (w_done0) begin
                r_cnt0 <= r_cnt0 + c_CNT_ONE;
                r_last <= 1'b0;
            end
            if (w_done1) begin
                r_cnt1 <= r_cnt1 + c_CNT_ONE;
                r_last <= 1'b1;
            end
            if (w_ill0 || w_ill1) begin
                r_perr <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Slave-side multiplexer
    // ------------------------------------------------------------------
    always_comb begin
        s_address    = 32'h0000_0000;
        s_writedata  = 32'h0000_0000;
        s_byteenable = 4'h0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        case (r_state)
            ST_GNT0: begin
                s_address    = m0_address;
                s_writedata  = m0_writedata;
                s_byteenable = m0_byteenable;
                s_read       = m0_read;
                s_write      = m0_write;
            end
            ST_GNT1: begin
                s_address    = m1_address;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
                s_read       = m1_read;
                s_write      = m1_write;
            end
            default: begin
                s_read       = 1'b0;
            end
        endcase
    end

    // A waiting master is stalled unless it owns the slave; idle or illegal masters never stall
    assign m0_waitrequest = w_req0 & ((r_state == ST_GNT0) ? s_waitrequest : 1'b1);
    assign m1_waitrequest = w_req1 & ((r_state == ST_GNT1) ? s_waitrequest : 1'b1);

    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    assign grant     = r_grant;
    assign proto_err = r_perr;
    assign m0_count  = r_cnt0;
    assign m1_count  = r_cnt1;

endmodule
`default_nettype wire

// File: doc/avl_arbiter.md
AVL_ARBITER -- requirements
Module: avl_arbiter

Interface
REQ-001 Parameter PRIORITY_MODE, default 0, meaning 0 = round-robin, 1 = fixed priority to m1.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-004 Ports m0_address/m0_writedata  input  32 each; m0_byteenable  input  4; m0_read/m0_write  input  1 each (m0 = instruction-fetch master).
REQ-005 Ports m0_readdata  output  32; m0_waitrequest  output  1.
REQ-006 Ports m1_* identical to m0_* (m1 = data master).
REQ-007 Ports s_address/s_writedata  output  32; s_byteenable  output  4; s_read/s_write  output  1 (to the shared Avalon slave memory).
REQ-008 Ports s_readdata  input  32; s_waitrequest  input  1.
REQ-009 Port grant  output  2  one-hot current owner ({m1,m0}); 00 when idle.
REQ-010 Port proto_err  output  1  sticky flag for illegal master requests.
REQ-011 Ports m0_count/m1_count  output  16 each  completed-transaction counters.

Function
REQ-012 A master requests when read XOR write is 1; read AND write both 1 is illegal.
REQ-013 States IDLE, GNT0, GNT1; state, grant, last-owner, counters and proto_err are registered.
REQ-014 IDLE: s_read = s_write = 0; s_address, s_writedata, s_byteenable = 0.
REQ-015 IDLE, exactly one legal request: next state is that master's GNTx.
REQ-016 IDLE, both legal requests, PRIORITY_MODE=0: grant the master other than last owner; PRIORITY_MODE=1: grant m1.
REQ-017 GNTx: all s_* request outputs combinationally equal mx_* inputs.
REQ-018 GNTx: mx_waitrequest = s_waitrequest; the other master's waitrequest = 1 if it requests.
REQ-019 A non-requesting master sees waitrequest = 0.
REQ-020 m0_readdata and m1_readdata both equal s_readdata at all times; valid only for the owner in its completion cycle.
REQ-021 Completion cycle: state GNTx, mx request asserted, s_waitrequest = 0.
REQ-022 On the edge ending a completion cycle: state -> IDLE; last owner <= x; mx_count increments.
REQ-023 GNTx with mx request dropped before completion: return to IDLE next edge; no count increment; last owner unchanged.
REQ-024 Illegal request (read=write=1): never granted; waitrequest = 0 for that master; proto_err set on next edge and held until reset.
REQ-025 Re-arbitration costs one IDLE cycle after every completion; a master is never granted twice in a row while the other waits in round-robin mode.
REQ-026 Counters wrap 16'hFFFF -> 16'h0000.
REQ-027 Reference latency with the shared memory (combinational waitrequest in its IDLE, BUSY 1 cycle, CHILL 1 cycle): request in cycle 0, grant in cycle 1, completion in cycle 3, IDLE in cycle 4.

Reset
REQ-028 rst = 0 immediately forces state IDLE, grant 00, last owner = m1 (so m0 wins the first tie), counters 0, proto_err 0, independent of clk.
REQ-029 Reset mid-transaction abandons it; no counter update; s_read/s_write drop to 0 during reset.
REQ-030 Release of rst takes effect at the first rising clk edge after deassertion.

Verification
REQ-031 Single read: m0 read 0xBFC00000, byteenable 4'hF, memory holds 0x3C011234 -> grant 01 in cycle 1, m0_waitrequest low in cycle 3 with m0_readdata 0x3C011234, m0_count 1.
REQ-032 Tie, PRIORITY_MODE=0: m0 read and m1 write 0xDEADBEEF to 0x00000010 held from cycle 0 -> m0 served first, m1 second; a later m1 read of 0x10 returns 0xDEADBEEF.
REQ-033 Tie, PRIORITY_MODE=1: both request continuously for 3 transactions -> m1 granted every time; m0_waitrequest stays 1.
REQ-034 Illegal: m1_read = m1_write = 1 for one cycle -> no grant, m1_waitrequest 0, proto_err 1 until rst = 0.
REQ-035 Reset mid-op: rst = 0 during GNT1 -> grant 00 and s_write 0 in the same cycle; memory contents unchanged; counters 0.
REQ-036 Wrap: preload via 65535 m0 reads, one more -> m0_count 0x0000, m1_count unaffected.
